// File: rtl/elastic_stage_buffer.sv
// Elastic pipeline register: a DEPTH-entry circular buffer between two pipeline
// stages, with valid/ready handshakes plus stage-level freeze (stall) and flush.
module elastic_stage_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             freeze,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  // Handshake: a beat moves on a side only in a cycle where both valid and
  // ready are high at the rising edge. in_ready never looks at out_ready, so a
  // full buffer refuses input even when it is being popped in the same cycle;
  // out_valid may drop (freeze) while out_data stays put.

  localparam int            PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  typedef enum logic [1:0] {
    OCC_EMPTY   = 2'd0,
    OCC_PARTIAL = 2'd1,
    OCC_FULL    = 2'd2
  } occ_e;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  occ_e             w_occ;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_occ = OCC_PARTIAL;
    if (r_count == '0)
      w_occ = OCC_EMPTY;
    else if (r_count == FULL_CNT)
      w_occ = OCC_FULL;
  end

  assign in_ready  = (w_occ != OCC_FULL) & ~flush;
  assign out_valid = (w_occ != OCC_EMPTY) & ~freeze;
  assign out_data  = (w_occ == OCC_EMPTY) ? '0 : r_mem[r_rd_ptr];
  assign count     = r_count;

  assign w_push = in_valid & in_ready;
  assign w_pop  = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push)
        r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)
        r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is deliberately not reset; a write while rst is low is dropped.
  always_ff @(posedge clk) begin
    if (w_push && rst)
      r_mem[r_wr_ptr] <= in_data;
  end

`ifndef SYNTHESIS
  a_count_bound: assert property (@(posedge clk) disable iff (!rst) r_count <= FULL_CNT);
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
                                  !((w_occ == OCC_FULL) && w_push));
  a_no_underflow: assert property (@(posedge clk) disable iff (!rst)
                                   !((w_occ == OCC_EMPTY) && w_pop));
`endif

endmodule
